dp_elastic_reg: RTL and testbench

Parametrised elastic pipeline stage register for the pipelined RV32 datapath, succeeding the fixed stall/flush stage register. It carries a WIDTH-bit payload between two pipeline stages using a valid/ready handshake. With DEPTH=2 it adds a skid entry, so ready can be registered without losing throughput. It keeps the legacy stall/flush controls used by the hazard logic, and counts wrong-path entries discarded by flush.

---
 rtl/dp_pkg.sv | 17 +
 rtl/sat_counter.sv | 36 +++
 rtl/dp_elastic_reg.sv | 118 +++++++++++
 tb/tb_dp_elastic_reg.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared types and limits for the elastic pipeline stage register.
package dp_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } dp_state_e;

  localparam int DP_DEPTH_MAX = 2;

  // The state encoding is chosen so that it equals the entry count.
  function automatic logic [1:0] dp_occupancy(input dp_state_e s);
    return logic'(s == ONE) ? 2'd1 : (s == TWO) ? 2'd2 : 2'd0;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: adds inc_i when en_i is set, sticking at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [1:0]       inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] b);
    logic [CNT_W+1:0] sum;
    logic [CNT_W+1:0] lim;
    sum = {2'b00, a} + {{CNT_W{1'b0}}, b};
    lim = {2'b00, {CNT_W{1'b1}}};
    return (sum > lim) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = sat_add(cnt_q, inc_i);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dp_elastic_reg.sv
// Elastic valid/ready pipeline stage with optional skid entry, hazard stall/flush
// controls and a saturating count of entries discarded by flush.
module dp_elastic_reg
  import dp_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] INIT_VALUE = {WIDTH{1'b0}},
  parameter int               DEPTH      = 2,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_cnt
);

  if (DEPTH < 1 || DEPTH > DP_DEPTH_MAX) begin : g_bad_depth
    $fatal(1, "dp_elastic_reg: DEPTH must be 1 or 2");
  end

  dp_state_e        state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;
  logic [1:0]       drop_inc;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_valid = (state_q != EMPTY) & ~stall;
  assign out_data  = main_q;
  assign occupancy = dp_occupancy(state_q);

  // Under stall both fires are already 0, so the handshake cases hold state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = INIT_VALUE;
      skid_d  = INIT_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire && DEPTH == 2) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= INIT_VALUE;
      skid_q  <= INIT_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Registered ready keeps the upstream handshake free of out_ready timing.
  if (DEPTH == 2) begin : g_reg_ready
    logic rdy_q;
    logic rdy_d;
    assign rdy_d = (state_d != TWO);
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) rdy_q <= 1'b0;
      else      rdy_q <= rdy_d;
    end
    assign in_ready = rdy_q & ~stall;
  end else begin : g_comb_ready
    assign in_ready = rst & ~stall & (~out_valid | out_ready);
  end

  assign drop_inc = occupancy + {1'b0, in_fire};

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst_ni(rst),
    .en_i  (flush),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt)
  );

endmodule

// File: tb/tb_dp_elastic_reg.sv
// Scoreboard bench: index 0 is a DEPTH=1 stage, index 1 a DEPTH=2 stage.
module tb_dp_elastic_reg;

  localparam logic [31:0] INITV = 32'h0001_0000;

  logic             clk = 1'b0;
  logic [1:0]       rstn = 2'b00;
  logic [1:0]       iv = '0, ir, ov, ordy = '0, st = '0, fl = '0;
  logic [1:0][31:0] id = '0, od;
  logic [1:0][1:0]  occ;
  logic [7:0]       dc1;
  logic [1:0]       dc2;
  logic [1:0][7:0]  dcv;

  int          total = 0;
  int          bad = 0;
  int          cur = 1;
  bit          mon_en = 0;
  logic [31:0] exp_q[$];
  int          drops = 0;
  bit          rdy_m = 0;

  always #5 clk = ~clk;

  assign dcv[0] = dc1;
  assign dcv[1] = {6'b0, dc2};

  dp_elastic_reg #(.WIDTH(32), .INIT_VALUE(INITV), .DEPTH(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst(rstn[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .stall(st[0]),
    .flush(fl[0]), .occupancy(occ[0]), .drop_cnt(dc1));

  dp_elastic_reg #(.WIDTH(32), .INIT_VALUE(INITV), .DEPTH(2), .CNT_W(2)) u_d2 (
    .clk(clk), .rst(rstn[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .stall(st[1]),
    .flush(fl[1]), .occupancy(occ[1]), .drop_cnt(dc2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (depth %0d): got %h expected %h", nm, cur + 1, act, exp);
    end
  endtask

  function automatic int drop_max();
    return (cur == 1) ? 3 : 255;
  endfunction

  // One clock cycle of stimulus; the model is a FIFO of accepted, undelivered payloads.
  task automatic cyc(input bit v, input logic [31:0] d, input bit o, input bit s, input bit f);
    int occ0;
    bit exp_ov, exp_ir, fire_in;
    @(negedge clk);
    chk("occupancy", 32'(occ[cur]), 32'(exp_q.size()));
    chk("drop_cnt", 32'(dcv[cur]), 32'(drops));
    iv[cur] = v; id[cur] = d; ordy[cur] = o; st[cur] = s; fl[cur] = f;
    occ0 = exp_q.size();
    #2;
    exp_ov = (occ0 > 0) && !s;
    exp_ir = (cur == 1) ? (rdy_m && !s) : (!s && (!exp_ov || o));
    chk("in_ready", 32'(ir[cur]), 32'(exp_ir));
    fire_in = v && exp_ir;
    if (fire_in) exp_q.push_back(d);
    if (f) begin
      drops = drops + occ0 + int'(fire_in);
      if (drops > drop_max()) drops = drop_max();
      exp_q.delete();
    end
    rdy_m = (exp_q.size() != 2);
  endtask

  task automatic after_edge_data(input string nm, input logic [31:0] exp);
    @(posedge clk);
    #1;
    chk(nm, od[cur], exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn[cur] = 1'b0;
    iv[cur] = 0; ordy[cur] = 0; st[cur] = 0; fl[cur] = 0; id[cur] = '0;
    exp_q.delete();
    drops = 0;
    rdy_m = 0;
    #1;
    chk("reset out_valid", 32'(ov[cur]), 32'd0);
    chk("reset in_ready", 32'(ir[cur]), 32'd0);
    chk("reset occupancy", 32'(occ[cur]), 32'd0);
    chk("reset drop_cnt", 32'(dcv[cur]), 32'd0);
    chk("reset out_data", od[cur], INITV);
    repeat (2) @(negedge clk);
    rstn[cur] = 1'b1;
    #1;
    chk("release in_ready", 32'(ir[cur]), (cur == 0) ? 32'd1 : 32'd0);
    rdy_m = 1;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0);
  endtask

  // Monitor: checks out_valid every cycle and pops the head on each delivery.
  initial begin
    bit exp_ov;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        exp_ov = (exp_q.size() > 0) && !st[cur];
        chk("out_valid", 32'(ov[cur]), 32'(exp_ov));
        if (exp_ov) begin
          chk("out_data", od[cur], exp_q[0]);
          if (ordy[cur]) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    cur = 1;
    mon_en = 1;
    do_reset();
    for (int k = 1; k <= 4; k++) cyc(1, k, 1, 0, 0);
    repeat (2) cyc(0, 0, 1, 0, 0);
    cyc(1, 32'hA, 0, 0, 0);
    cyc(1, 32'hB, 0, 0, 0);
    cyc(1, 32'hC, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0);
    cyc(1, 32'hF1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    after_edge_data("flush one out_data", INITV);
    cyc(1, 32'h61, 0, 0, 0);
    cyc(1, 32'h62, 0, 0, 0);
    cyc(1, 32'h63, 0, 0, 1);
    after_edge_data("flush two out_data", INITV);
    cyc(1, 32'h71, 0, 0, 0);
    cyc(1, 32'h72, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 32'hDEAD, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    after_edge_data("stall out_data", 32'hDEAD);
    cyc(0, 0, 1, 1, 0);
    after_edge_data("stall out_data", 32'hDEAD);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    random_run(400);

    cur = 0;
    do_reset();
    random_run(400);
    cyc(0, 0, 1, 0, 1);
    cyc(1, 32'h11, 0, 0, 0);
    cyc(1, 32'h22, 0, 0, 0);
    cyc(1, 32'h33, 1, 1, 1);
    after_edge_data("d1 stall+flush out_data", INITV);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 32'h44, 1, 0, 0);
    do_reset();
    cyc(1, 32'h55, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
